// File: rtl/mult_pkg.sv
// mult_pkg: shared helpers for the limb-serial stream multiplier.
package mult_pkg;
  function automatic int num_limbs(input int dat_bits, input int limb_bits);
    return (dat_bits + limb_bits - 1) / limb_bits;
  endfunction
endpackage

// File: rtl/mult_limb_stage.sv
// mult_limb_stage: one pipeline stage adding A*B[IDX] << IDX*LIMB_BITS into acc.
module mult_limb_stage #(
  parameter int DAT_BITS  = 381,
  parameter int CTL_BITS  = 8,
  parameter int LIMB_BITS = 17,
  parameter int NUM_LIMBS = 23,
  parameter int IDX       = 0,
  localparam int PW = 2*DAT_BITS,
  localparam int BW = NUM_LIMBS*LIMB_BITS,
  localparam int SW = 1+CTL_BITS+DAT_BITS+BW+PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [SW-1:0] st_i,
  output logic [SW-1:0] st_o
);
  typedef struct packed {
    logic                val;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] a;
    logic [BW-1:0]       b;
    logic [PW-1:0]       acc;
  } stage_t;
  stage_t in_s, st_d, st_q;
  logic [LIMB_BITS-1:0] limb;
  logic [DAT_BITS+LIMB_BITS-1:0] pp;
  assign in_s = st_i;
  assign limb = in_s.b[IDX*LIMB_BITS +: LIMB_BITS];
  assign pp = (DAT_BITS+LIMB_BITS)'(in_s.a) * (DAT_BITS+LIMB_BITS)'(limb);
  always_comb begin
    st_d = in_s;
    st_d.acc = in_s.acc + (PW'(pp) << (IDX*LIMB_BITS));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= '0;
    else if (en_i) st_q <= st_d;
  assign st_o = st_q;
endmodule

// File: rtl/mult_stream_pipe.sv
// mult_stream_pipe: flow-controlled pipelined A*B stream multiplier, one B limb per stage.
// Optional 2-entry registered-ready input skid buffer enabled by MULT_PIPE_SKID_EN.
module mult_stream_pipe import mult_pkg::*; #(
  parameter int DAT_BITS  = 381,
  parameter int CTL_BITS  = 8,
  parameter int LIMB_BITS = 17,
  parameter int NUM_LIMBS = num_limbs(DAT_BITS, LIMB_BITS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mul_val,
  output logic                  i_mul_rdy,
  input  logic [2*DAT_BITS-1:0] i_mul_dat,
  input  logic [CTL_BITS-1:0]   i_mul_ctl,
  input  logic                  i_mul_sop,
  input  logic                  i_mul_eop,
  output logic                  o_mul_val,
  input  logic                  o_mul_rdy,
  output logic [2*DAT_BITS-1:0] o_mul_dat,
  output logic [CTL_BITS-1:0]   o_mul_ctl,
  output logic                  o_mul_sop,
  output logic                  o_mul_eop,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int PW = 2*DAT_BITS;
  localparam int BW = NUM_LIMBS*LIMB_BITS;
  localparam int SW = 1+CTL_BITS+DAT_BITS+BW+PW;
`ifdef MULT_PIPE_SKID_EN
  localparam int CW = $clog2(NUM_LIMBS+5);
`else
  localparam int CW = $clog2(NUM_LIMBS+3);
`endif
  typedef struct packed {
    logic                val;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] a;
    logic [BW-1:0]       b;
    logic [PW-1:0]       acc;
  } stage_t;
  logic adv, src_val, in_hs, out_hs, err_q, err_d, o_val_q, unused_ab;
  logic [PW-1:0] src_dat, o_dat_q;
  logic [CTL_BITS-1:0] src_ctl, o_ctl_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_LIMBS:0][SW-1:0] st;
  stage_t s0_d, s0_q, last;
  assign adv = ~o_val_q | o_mul_rdy;
`ifdef MULT_PIPE_SKID_EN
  logic [CTL_BITS+PW-1:0] skid_q [2];
  logic wr_q, rd_q, rdy_q, push, pop;
  logic [1:0] fill_q, fill_d;
  assign push = i_mul_val & rdy_q;
  assign pop = (fill_q != 2'd0) & adv;
  assign fill_d = fill_q + {1'b0, push} - {1'b0, pop};
  // Ready is registered so it never depends combinationally on o_mul_rdy.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      fill_q <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      wr_q <= wr_q ^ push;
      rd_q <= rd_q ^ pop;
      fill_q <= fill_d;
      rdy_q <= fill_d != 2'd2;
    end
  always_ff @(posedge i_clk)
    if (push) skid_q[wr_q] <= {i_mul_ctl, i_mul_dat};
  assign i_mul_rdy = rdy_q;
  assign src_val = fill_q != 2'd0;
  assign {src_ctl, src_dat} = skid_q[rd_q];
`else
  assign i_mul_rdy = adv;
  assign src_val = i_mul_val;
  assign src_dat = i_mul_dat;
  assign src_ctl = i_mul_ctl;
`endif
  assign s0_d = '{val: src_val, ctl: src_ctl, a: src_dat[DAT_BITS-1:0],
                  b: BW'(src_dat[PW-1:DAT_BITS]), acc: '0};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) s0_q <= '0;
    else if (adv) s0_q <= s0_d;
  assign st[0] = s0_q;
  for (genvar k = 1; k <= NUM_LIMBS; k++) begin : g_stage
    mult_limb_stage #(
      .DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS), .LIMB_BITS(LIMB_BITS),
      .NUM_LIMBS(NUM_LIMBS), .IDX(k-1)
    ) u_stage (
      .clk(i_clk), .rst_n(i_rst_n), .en_i(adv), .st_i(st[k-1]), .st_o(st[k])
    );
  end
  assign last = st[NUM_LIMBS];
  assign unused_ab = ^{last.a, last.b};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_val_q <= 1'b0;
      o_dat_q <= '0;
      o_ctl_q <= '0;
    end else if (adv) begin
      o_val_q <= last.val;
      o_dat_q <= last.acc;
      o_ctl_q <= last.ctl;
    end
  assign in_hs = i_mul_val & i_mul_rdy;
  assign out_hs = o_val_q & o_mul_rdy;
  assign cnt_d = cnt_q + CW'(in_hs) - CW'(out_hs);
  assign err_d = err_q | (i_mul_val & ~(i_mul_sop & i_mul_eop))
               | (in_hs & ~out_hs & (&cnt_q)) | (out_hs & ~in_hs & (cnt_q == '0));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign o_mul_val = o_val_q;
  assign o_mul_dat = o_dat_q;
  assign o_mul_ctl = o_ctl_q;
  assign o_mul_sop = o_val_q;
  assign o_mul_eop = o_val_q;
  assign o_busy = cnt_q != '0;
  assign o_err = err_q;
endmodule

// File: tb/tb_mult_stream_pipe.sv
// tb_mult_stream_pipe: scoreboard bench for mult_stream_pipe (16-bit main DUT, 20-bit partial-limb DUT).
module tb_mult_stream_pipe;
  localparam int NL = 2;
  localparam int NL20 = 3;
`ifdef MULT_PIPE_SKID_EN
  localparam int LAT = NL + 2;
  localparam int LAT20 = NL20 + 2;
  localparam int CAP = NL + 4;
`else
  localparam int LAT = NL + 1;
  localparam int LAT20 = NL20 + 1;
  localparam int CAP = NL + 2;
`endif
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] prod;
  } exp_t;

  logic clk = 1'b0, rst_n;
  logic i_val, i_rdy, i_sop, i_eop, o_val, o_rdy, o_sop, o_eop, busy, err;
  logic [31:0] i_dat, o_dat;
  logic [7:0] i_ctl, o_ctl;
  logic v20, r20, ov20, sop20, eop20, busy20, err20;
  logic [39:0] d20, od20;
  logic [7:0] oc20;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, n_out = 0, first_out = 0, last_out = 0;
  int t, n_acc;
  logic acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_stream_pipe #(.DAT_BITS(16), .CTL_BITS(8), .LIMB_BITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mul_val(i_val), .i_mul_rdy(i_rdy), .i_mul_dat(i_dat), .i_mul_ctl(i_ctl),
    .i_mul_sop(i_sop), .i_mul_eop(i_eop),
    .o_mul_val(o_val), .o_mul_rdy(o_rdy), .o_mul_dat(o_dat), .o_mul_ctl(o_ctl),
    .o_mul_sop(o_sop), .o_mul_eop(o_eop), .o_busy(busy), .o_err(err));

  mult_stream_pipe #(.DAT_BITS(20), .CTL_BITS(8), .LIMB_BITS(8)) dut20 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mul_val(v20), .i_mul_rdy(r20), .i_mul_dat(d20), .i_mul_ctl(8'hC3),
    .i_mul_sop(1'b1), .i_mul_eop(1'b1),
    .o_mul_val(ov20), .o_mul_rdy(1'b1), .o_mul_dat(od20), .o_mul_ctl(oc20),
    .o_mul_sop(sop20), .o_mul_eop(eop20), .o_busy(busy20), .o_err(err20));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) if (rst_n) begin
    if (o_val && o_rdy) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("out_dat", o_dat, e.prod);
        check("out_ctl", o_ctl, e.ctl);
        check("out_sop_eop", {o_sop, o_eop}, 2'b11);
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
    end
    if (i_val && i_rdy) q.push_back('{i_ctl, 32'(i_dat[15:0]) * 32'(i_dat[31:16])});
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c, input logic s);
    int n;
    i_val = 1'b1; i_dat = {b, a}; i_ctl = c; i_sop = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_rdy && n < 50);
    check("send_rdy", i_rdy, 1);
    @(posedge clk); #1;
    i_val = 1'b0; i_sop = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (q.size() == 0) break;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk); @(negedge clk);
    check("busy_drop", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; i_val = 1'b0; i_dat = '0; i_ctl = '0; i_sop = 1'b1; i_eop = 1'b1;
    o_rdy = 1'b1; v20 = 1'b0; d20 = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_val", o_val, 0);
    check("rst_dat", o_dat, 0);
    check("rst_ctl", o_ctl, 0);
    check("rst_sop_eop", {o_sop, o_eop}, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", i_rdy, 1);
    @(posedge clk); #1;

    send(16'hFFFF, 16'hFFFF, 8'h5A, 1'b1);
    t = cyc;
    for (int n = 0; n < 20 && !o_val; n++) @(negedge clk);
    check("latency_val", o_val, 1);
    check("latency_cycles", cyc - t, LAT);
    drain();

    send(16'h0000, 16'h1234, 8'h01, 1'b1);
    send(16'h1234, 16'h0000, 8'h02, 1'b1);
    send(16'hFFFF, 16'h0001, 8'h03, 1'b1);
    drain();

    n_out = 0;
    for (int i = 0; i < 100; i++) send(16'($urandom), 16'($urandom), 8'(i), 1'b1);
    drain();
    check("rand_count", n_out, 100);
    check("rand_throughput", last_out - first_out, 99);

    o_rdy = 1'b0; n_acc = 0;
    i_val = 1'b1; i_dat = $urandom; i_ctl = 8'hA0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      acc = i_rdy;
      if (acc) n_acc++;
      @(posedge clk); #1;
      if (acc) begin i_dat = $urandom; i_ctl = i_ctl + 8'd1; end
    end
    i_val = 1'b0;
    check("stall_accepted", n_acc, CAP);
    check("stall_busy", busy, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_val", o_val, 1);
      check("stall_rdy_low", i_rdy, 0);
      check("stall_dat", o_dat, q[0].prod);
      check("stall_ctl", o_ctl, q[0].ctl);
    end
    @(posedge clk); #1;
    o_rdy = 1'b1;
    drain();

    check("err_clear", err, 0);
    send(16'h0102, 16'h0304, 8'hEE, 1'b0);
    check("err_set", err, 1);
    drain();
    check("err_sticky", err, 1);

    send(16'h1111, 16'h2222, 8'h10, 1'b1);
    send(16'h3333, 16'h4444, 8'h11, 1'b1);
    send(16'h5555, 16'h6666, 8'h12, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_val", o_val, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_val", o_val, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    v20 = 1'b1; d20 = {20'hFFFFF, 20'hFFFFF};
    for (int n = 0; n < 20 && !r20; n++) @(negedge clk);
    if (!r20) @(negedge clk);
    check("w20_rdy", r20, 1);
    @(posedge clk); #1;
    v20 = 1'b0;
    t = cyc;
    for (int n = 0; n < 20 && !ov20; n++) @(negedge clk);
    check("w20_val", ov20, 1);
    check("w20_latency", cyc - t, LAT20);
    check("w20_dat", od20, 40'hFFFFE00001);
    check("w20_ctl", oc20, 8'hC3);
    check("w20_sop_eop", {sop20, eop20}, 2'b11);
    repeat (2) @(negedge clk);
    check("w20_busy", busy20, 0);
    check("w20_err", err20, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
